// File: rtl/aes_round.sv
// aes_round: one AES-128 round per clock with a registered output.
// ENCRYPT : out <= MixColumns(ShiftRows(SubBytes(state))) ^ key
// DECRYPT : out <= InvSubBytes(InvShiftRows(InvMixColumns(state ^ key)))
// The inverse datapath exists only when AES_ROUND_DECRYPT_EN is defined;
// without it DECRYPT is an unsupported job type and out holds.
// Any other job type holds out. Byte 0 is state[127:120], column-major.
// No handshake: a new input is accepted every cycle and its result is
// visible after the next rising edge.

package aes_round_pkg;
  typedef enum logic [1:0] {
    JOB_IDLE = 2'd0,
    ENCRYPT  = 2'd1,
    DECRYPT  = 2'd2,
    JOB_RSVD = 2'd3
  } job_t;
endpackage

module aes_round
  import aes_round_pkg::*;
(
  input  logic         clk,
  input  logic         rst_n,
  input  logic [127:0] state,
  input  job_t         in_type,
  input  logic [127:0] key,
  output logic [127:0] out
);

  // GF(2^8) multiply by x, reduction polynomial 0x11B.
  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  // General GF(2^8) multiply (shift-and-add with xtime).
  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] aa;
    p  = 8'h00;
    aa = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ aa;
      aa = xtime(aa);
    end
    return p;
  endfunction

  // Multiplicative inverse as x^254 (maps 0 to 0, as the S-box requires).
  function automatic logic [7:0] gf_inv(input logic [7:0] x);
    logic [7:0] x2, x3, x6, x12, x15, x30, x60, x120, x240;
    x2   = gf_mul(x, x);
    x3   = gf_mul(x2, x);
    x6   = gf_mul(x3, x3);
    x12  = gf_mul(x6, x6);
    x15  = gf_mul(x12, x3);
    x30  = gf_mul(x15, x15);
    x60  = gf_mul(x30, x30);
    x120 = gf_mul(x60, x60);
    x240 = gf_mul(x120, x120);
    return gf_mul(gf_mul(x240, x12), x2);
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
    return (b << n) | (b >> (8 - n));
  endfunction

  // Forward S-box: inversion followed by the FIPS-197 affine map.
  function automatic logic [7:0] sbox(input logic [7:0] x);
    logic [7:0] v;
    v = gf_inv(x);
    return v ^ rotl8(v, 1) ^ rotl8(v, 2) ^ rotl8(v, 3) ^ rotl8(v, 4) ^ 8'h63;
  endfunction

  function automatic logic [127:0] sub_bytes(input logic [127:0] s);
    logic [127:0] r;
    r = '0;
    for (int i = 0; i < 16; i++) r[127-8*i -: 8] = sbox(s[127-8*i -: 8]);
    return r;
  endfunction

  // Row r of the output takes column (c + r) mod 4 of the input.
  function automatic logic [127:0] shift_rows(input logic [127:0] s);
    logic [127:0] r;
    r = '0;
    for (int c = 0; c < 4; c++)
      for (int w = 0; w < 4; w++)
        r[127-8*(4*c+w) -: 8] = s[127-8*(4*((c+w)%4)+w) -: 8];
    return r;
  endfunction

  function automatic logic [127:0] mix_columns(input logic [127:0] s);
    logic [127:0] r;
    logic [7:0]   a0, a1, a2, a3;
    r = '0;
    for (int c = 0; c < 4; c++) begin
      a0 = s[127-32*c -: 8];
      a1 = s[119-32*c -: 8];
      a2 = s[111-32*c -: 8];
      a3 = s[103-32*c -: 8];
      r[127-32*c -: 8] = xtime(a0) ^ (xtime(a1) ^ a1) ^ a2 ^ a3;
      r[119-32*c -: 8] = a0 ^ xtime(a1) ^ (xtime(a2) ^ a2) ^ a3;
      r[111-32*c -: 8] = a0 ^ a1 ^ xtime(a2) ^ (xtime(a3) ^ a3);
      r[103-32*c -: 8] = (xtime(a0) ^ a0) ^ a1 ^ a2 ^ xtime(a3);
    end
    return r;
  endfunction

`ifdef AES_ROUND_DECRYPT_EN
  // Inverse S-box: inverse affine map followed by inversion.
  function automatic logic [7:0] inv_sbox(input logic [7:0] y);
    return gf_inv(rotl8(y, 1) ^ rotl8(y, 3) ^ rotl8(y, 6) ^ 8'h05);
  endfunction

  function automatic logic [127:0] inv_sub_bytes(input logic [127:0] s);
    logic [127:0] r;
    r = '0;
    for (int i = 0; i < 16; i++) r[127-8*i -: 8] = inv_sbox(s[127-8*i -: 8]);
    return r;
  endfunction

  // Row r of the output takes column (c - r) mod 4 of the input.
  function automatic logic [127:0] inv_shift_rows(input logic [127:0] s);
    logic [127:0] r;
    r = '0;
    for (int c = 0; c < 4; c++)
      for (int w = 0; w < 4; w++)
        r[127-8*(4*c+w) -: 8] = s[127-8*(4*((c-w+4)%4)+w) -: 8];
    return r;
  endfunction

  function automatic logic [127:0] inv_mix_columns(input logic [127:0] s);
    logic [127:0] r;
    logic [7:0]   a0, a1, a2, a3;
    r = '0;
    for (int c = 0; c < 4; c++) begin
      a0 = s[127-32*c -: 8];
      a1 = s[119-32*c -: 8];
      a2 = s[111-32*c -: 8];
      a3 = s[103-32*c -: 8];
      r[127-32*c -: 8] = gf_mul(a0, 8'h0e) ^ gf_mul(a1, 8'h0b) ^ gf_mul(a2, 8'h0d) ^ gf_mul(a3, 8'h09);
      r[119-32*c -: 8] = gf_mul(a0, 8'h09) ^ gf_mul(a1, 8'h0e) ^ gf_mul(a2, 8'h0b) ^ gf_mul(a3, 8'h0d);
      r[111-32*c -: 8] = gf_mul(a0, 8'h0d) ^ gf_mul(a1, 8'h09) ^ gf_mul(a2, 8'h0e) ^ gf_mul(a3, 8'h0b);
      r[103-32*c -: 8] = gf_mul(a0, 8'h0b) ^ gf_mul(a1, 8'h0d) ^ gf_mul(a2, 8'h09) ^ gf_mul(a3, 8'h0e);
    end
    return r;
  endfunction
`endif

  logic [127:0] out_d;
  logic [127:0] out_q;

  // Select this cycle's round result; unsupported job types hold the output.
  always_comb begin
    out_d = out_q;
    case (in_type)
      ENCRYPT: out_d = mix_columns(shift_rows(sub_bytes(state))) ^ key;
`ifdef AES_ROUND_DECRYPT_EN
      DECRYPT: out_d = inv_sub_bytes(inv_shift_rows(inv_mix_columns(state ^ key)));
`endif
      default: out_d = out_q;
    endcase
  end

  // Output register; reset clears it without waiting for a clock edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) out_q <= '0;
    else        out_q <= out_d;
  end

  assign out = out_q;

endmodule

// File: tb/tb_aes_round.sv
// Bench for aes_round: the driver pushes one expected value per issued
// cycle, a monitor pops and compares one edge later. Expectations follow
// AES_ROUND_DECRYPT_EN: with it undefined, DECRYPT holds the output.
`timescale 1ns/1ps
module tb_aes_round;
  import aes_round_pkg::*;

  localparam logic [127:0] C1_IN  = 128'h00102030405060708090a0b0c0d0e0f0;
  localparam logic [127:0] C1_KEY = 128'hd6aa74fdd2af72fadaa678f1d6ab76fe;
  localparam logic [127:0] C1_OUT = 128'h89d810e8855ace682d1843d8cb128fe4;
  localparam logic [127:0] ALL63  = 128'h63636363636363636363636363636363;
  localparam logic [127:0] ALL01  = 128'h01010101010101010101010101010101;
  localparam logic [127:0] ALL7C  = 128'h7c7c7c7c7c7c7c7c7c7c7c7c7c7c7c7c;
  localparam logic [127:0] ALLFF  = {128{1'b1}};
  localparam logic [127:0] ALL9C  = 128'h9c9c9c9c9c9c9c9c9c9c9c9c9c9c9c9c;

  logic         clk;
  logic         rst_n;
  logic [127:0] state;
  job_t         in_type;
  logic [127:0] key;
  logic [127:0] dut_out;

  logic [127:0] exp_q[$];
  logic [127:0] last_exp;
  int           n_checks;
  int           n_fail;

  aes_round dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .state   (state),
    .in_type (in_type),
    .key     (key),
    .out     (dut_out)
  );

  // Clock and reset defaults
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %032h expected %032h", name, act, exp);
    end
  endtask

  // Driver tasks: apply inputs at the falling edge and push the expectation
  task automatic drive(input job_t t, input logic [127:0] s, input logic [127:0] k,
                       input logic [127:0] exp);
    @(negedge clk);
    in_type = t;
    state   = s;
    key     = k;
    exp_q.push_back(exp);
    last_exp = exp;
  endtask

  task automatic drive_enc(input logic [127:0] s, input logic [127:0] k, input logic [127:0] exp);
    drive(ENCRYPT, s, k, exp);
  endtask

  task automatic drive_dec(input logic [127:0] s, input logic [127:0] k, input logic [127:0] exp);
`ifdef AES_ROUND_DECRYPT_EN
    drive(DECRYPT, s, k, exp);
`else
    drive(DECRYPT, s, k, last_exp);
`endif
  endtask

  task automatic drive_hold(input job_t t, input logic [127:0] s, input logic [127:0] k);
    drive(t, s, k, last_exp);
  endtask

  // Scoreboard monitor: one result per issued cycle, sampled after the edge
  initial begin
    forever begin
      @(posedge clk);
      #2;
      if (exp_q.size() > 0) check("round_out", dut_out, exp_q.pop_front());
    end
  end

  initial begin
    n_checks = 0;
    n_fail   = 0;
    last_exp = '0;
    rst_n    = 1'b1;
    in_type  = ENCRYPT;
    state    = {$urandom, $urandom, $urandom, $urandom};
    key      = {$urandom, $urandom, $urandom, $urandom};

    // Reset with arbitrary inputs: output clears before any clock edge
    #2 rst_n = 1'b0;
    #1 check("reset_async", dut_out, 128'h0);
    repeat (2) @(posedge clk);
    #1 check("reset_held", dut_out, 128'h0);
    @(negedge clk);
    in_type = JOB_IDLE;
    rst_n   = 1'b1;

    // Directed single rounds
    drive_enc(C1_IN, C1_KEY, C1_OUT);
    drive_enc('0, '0, ALL63);
    drive_dec(C1_OUT, C1_KEY, C1_IN);
    drive_dec(ALL63, '0, '0);
    drive_enc(ALL01, '0, ALL7C);
    drive_enc('0, ALLFF, ALL9C);
    drive_dec(ALL7C, '0, ALL01);

    // Back-to-back alternating job types
    drive_enc(C1_IN, C1_KEY, C1_OUT);
    drive_dec(C1_OUT, C1_KEY, C1_IN);
    drive_enc('0, '0, ALL63);
    drive_dec(ALL63, '0, '0);
    drive_enc(C1_IN, C1_KEY, C1_OUT);
    drive_dec(C1_OUT, C1_KEY, C1_IN);

    // Unsupported job types hold the previous result
    drive_enc(C1_IN, C1_KEY, C1_OUT);
    drive_hold(JOB_IDLE, '0, '0);
    drive_hold(JOB_RSVD, ALL01, ALLFF);
    drive_dec(C1_OUT, C1_KEY, C1_IN);
    drive_enc(C1_IN, C1_KEY, C1_OUT);

    // Reset mid-stream: output clears without a clock edge
    @(negedge clk);
    in_type = JOB_IDLE;
    check("pre_reset_value", dut_out, C1_OUT);
    #1 rst_n = 1'b0;
    #1 check("reset_midstream", dut_out, 128'h0);
    in_type = ENCRYPT;
    state   = C1_IN;
    key     = C1_KEY;
    @(posedge clk);
    #1 check("reset_blocks_load", dut_out, 128'h0);
    @(negedge clk);
    rst_n    = 1'b1;
    in_type  = JOB_IDLE;
    last_exp = '0;
    drive_hold(JOB_IDLE, C1_IN, C1_KEY);
    drive_enc('0, '0, ALL63);

    // Drain the scoreboard within a bounded number of cycles
    for (int i = 0; i < 20 && exp_q.size() > 0; i++) @(posedge clk);
    #3;
    if (exp_q.size() > 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL drain: %0d results never observed, expected 0", exp_q.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
